// File: rtl/fft_bfly_r2.sv
// Pipelined radix-2 DIT butterfly: sum = A + W*B, sub = A - W*B, with saturation, optional halving and a sticky ovf flag.
// Define FFT_BFLY_ROUND_EN for round-half-up at both shifts; leave it undefined for floor truncation.
module fft_bfly_r2 #(
  parameter int DW = 16,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] INar,
  input  logic [DW-1:0] INai,
  input  logic [DW-1:0] INbr,
  input  logic [DW-1:0] INbi,
  input  logic [TW-1:0] INwr,
  input  logic [TW-1:0] INwi,
  input  logic          scale,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW:0]   OUTsumr,
  output logic [DW:0]   OUTsumi,
  output logic [DW:0]   OUTsubr,
  output logic [DW:0]   OUTsubi,
  output logic          ovf,
  input  logic          clr_ovf
);

  localparam int PW = DW + TW;
  localparam int SW = PW + 1;

`ifdef FFT_BFLY_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  localparam logic signed [SW-1:0] PRND = ROUND ? (SW'(1) << (TW-2)) : '0;
  localparam logic signed [SW-1:0] SMAX = {{(TW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(TW+2){1'b1}}, {(DW-1){1'b0}}};

  logic en;
  logic [3:0] vld_q;

  assign en        = !vld_q[3] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q[3];

  // S1: operand capture
  logic [DW-1:0] ar1_q, ai1_q, br1_q, bi1_q;
  logic [TW-1:0] wr1_q, wi1_q;
  logic          sc1_q;
  // S2: partial products
  logic signed [PW-1:0] prr2_q, pii2_q, pri2_q, pir2_q;
  logic [DW-1:0] ar2_q, ai2_q;
  logic          sc2_q;
  // S3: saturated twiddle product
  logic [DW-1:0] tr3_q, ti3_q, ar3_q, ai3_q;
  logic          sat3_q, sc3_q;
  // S4: registered outputs
  logic [DW:0]   sumr_q, sumi_q, subr_q, subi_q;
  logic          ovf_q;

  logic signed [SW-1:0] pr_w, pi_w, prs_w, pis_w;
  logic                 tr_hi, tr_lo, ti_hi, ti_lo;
  logic [DW-1:0]        tr_d, ti_d;
  logic [DW:0]          sumr_d, sumi_d, subr_d, subi_d;
  logic                 ovf_d;

  always_comb begin
    pr_w  = {prr2_q[PW-1], prr2_q} - {pii2_q[PW-1], pii2_q};
    pi_w  = {pri2_q[PW-1], pri2_q} + {pir2_q[PW-1], pir2_q};
    prs_w = (pr_w + PRND) >>> (TW-1);
    pis_w = (pi_w + PRND) >>> (TW-1);
    tr_hi = prs_w > SMAX;
    tr_lo = prs_w < SMIN;
    ti_hi = pis_w > SMAX;
    ti_lo = pis_w < SMIN;
    tr_d  = tr_hi ? {1'b0, {(DW-1){1'b1}}} : tr_lo ? {1'b1, {(DW-1){1'b0}}} : prs_w[DW-1:0];
    ti_d  = ti_hi ? {1'b0, {(DW-1){1'b1}}} : ti_lo ? {1'b1, {(DW-1){1'b0}}} : pis_w[DW-1:0];
  end

  // Halving: floor(v/2), plus the dropped LSB when rounding (equals (v+1)>>>1).
  function automatic logic [DW:0] halve(input logic [DW:0] v, input logic sc);
    logic [DW:0] h;
    h = {v[DW], v[DW:1]} + (DW+1)'(ROUND & v[0]);
    return sc ? h : v;
  endfunction

  always_comb begin
    sumr_d = halve({ar3_q[DW-1], ar3_q} + {tr3_q[DW-1], tr3_q}, sc3_q);
    sumi_d = halve({ai3_q[DW-1], ai3_q} + {ti3_q[DW-1], ti3_q}, sc3_q);
    subr_d = halve({ar3_q[DW-1], ar3_q} - {tr3_q[DW-1], tr3_q}, sc3_q);
    subi_d = halve({ai3_q[DW-1], ai3_q} - {ti3_q[DW-1], ti3_q}, sc3_q);
    ovf_d  = ovf_q;
    if (clr_ovf)
      ovf_d = 1'b0;
    if (en && vld_q[2] && sat3_q)
      ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      sumr_q <= '0;
      sumi_q <= '0;
      subr_q <= '0;
      subi_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (en) begin
        vld_q  <= {vld_q[2:0], in_valid};
        sumr_q <= sumr_d;
        sumi_q <= sumi_d;
        subr_q <= subr_d;
        subi_q <= subi_d;
      end
    end
  end

  // Datapath registers need no reset: the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (en) begin
      ar1_q  <= INar;
      ai1_q  <= INai;
      br1_q  <= INbr;
      bi1_q  <= INbi;
      wr1_q  <= INwr;
      wi1_q  <= INwi;
      sc1_q  <= scale;
      prr2_q <= $signed(br1_q) * $signed(wr1_q);
      pii2_q <= $signed(bi1_q) * $signed(wi1_q);
      pri2_q <= $signed(br1_q) * $signed(wi1_q);
      pir2_q <= $signed(bi1_q) * $signed(wr1_q);
      ar2_q  <= ar1_q;
      ai2_q  <= ai1_q;
      sc2_q  <= sc1_q;
      tr3_q  <= tr_d;
      ti3_q  <= ti_d;
      sat3_q <= tr_hi | tr_lo | ti_hi | ti_lo;
      ar3_q  <= ar2_q;
      ai3_q  <= ai2_q;
      sc3_q  <= sc2_q;
    end
  end

  assign OUTsumr = sumr_q;
  assign OUTsumi = sumi_q;
  assign OUTsubr = subr_q;
  assign OUTsubi = subi_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_fft_bfly_r2.sv
// Directed self-checking bench for fft_bfly_r2 (DW=TW=16); expectations follow FFT_BFLY_ROUND_EN.
module tb_fft_bfly_r2;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] INar = '0, INai = '0, INbr = '0, INbi = '0, INwr = '0, INwi = '0;
  logic        scale = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [16:0] OUTsumr, OUTsumi, OUTsubr, OUTsubi;
  logic        ovf;
  logic        clr_ovf = 1'b0;

  int errors = 0;
  int checks = 0;

  fft_bfly_r2 #(.DW(16), .TW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .INar(INar), .INai(INai), .INbr(INbr), .INbi(INbi), .INwr(INwr), .INwi(INwi),
    .scale(scale), .out_valid(out_valid), .out_ready(out_ready),
    .OUTsumr(OUTsumr), .OUTsumi(OUTsumi), .OUTsubr(OUTsubr), .OUTsubi(OUTsubi),
    .ovf(ovf), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  // Drives one sample and waits for its output; lat = edges after acceptance, -1 on timeout.
  task automatic run_one(input logic [15:0] ar, ai, br, bi, wr, wi, input logic sc, output int lat);
    @(negedge clk);
    INar = ar; INai = ai; INbr = br; INbi = bi; INwr = wr; INwi = wi;
    scale = sc; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: got vld=%b ovf=%b rdy=%b want 0 0 1", out_valid, ovf, in_ready);
    end
    checks++;
    if ({OUTsumr, OUTsumi, OUTsubr, OUTsubi} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h want all 0", OUTsumr, OUTsumi, OUTsubr, OUTsubi);
    end
  endtask

  task automatic test_basic;
    int lat;
    // W = -1.0 exactly, so T = -B.
    run_one(16'd100, 16'd0, 16'd50, 16'd0, 16'h8000, 16'd0, 1'b0, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 3", lat);
    end
    checks++;
    if (OUTsumr !== 17'd50 || OUTsumi !== 17'd0 || OUTsubr !== 17'd150 || OUTsubi !== 17'd0) begin
      errors++;
      $display("FAIL basic_data: got %0d %0d %0d %0d want 50 0 150 0",
               $signed(OUTsumr), $signed(OUTsumi), $signed(OUTsubr), $signed(OUTsubi));
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_ovf: got %b want 0", ovf);
    end
  endtask

  task automatic test_saturation;
    int lat;
    logic [16:0] e_sum_i, e_sub_i;
    e_sum_i = 17'd32767;
    e_sub_i = -17'sd32767;
    run_one(16'd0, 16'd0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0, lat);
    checks++;
    if (lat !== 3 || OUTsumr !== 17'd0 || OUTsumi !== e_sum_i || OUTsubr !== 17'd0 || OUTsubi !== e_sub_i) begin
      errors++;
      $display("FAIL sat_data: lat=%0d got %0d %0d %0d %0d want 0 32767 0 -32767", lat,
               $signed(OUTsumr), $signed(OUTsumi), $signed(OUTsubr), $signed(OUTsubi));
    end
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL sat_ovf_set: got %b want 1", ovf);
    end
    // A clean sample must leave the sticky flag alone.
    run_one(16'd1, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, lat);
    checks++;
    if (ovf !== 1'b1 || OUTsumr !== 17'd1 || OUTsumi !== 17'd2) begin
      errors++;
      $display("FAIL sat_ovf_sticky: got ovf=%b sum=%0d,%0d want 1 1,2", ovf, $signed(OUTsumr), $signed(OUTsumi));
    end
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL sat_ovf_clear: got %b want 0", ovf);
    end
  endtask

  task automatic test_scale;
    int lat;
    logic [16:0] er, ei;
`ifdef FFT_BFLY_ROUND_EN
    er = 17'd2;  ei = -17'sd1;
`else
    er = 17'd1;  ei = -17'sd2;
`endif
    run_one(16'd3, -16'sd3, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, lat);
    checks++;
    if (lat !== 3 || OUTsumr !== er || OUTsumi !== ei || OUTsubr !== er || OUTsubi !== ei) begin
      errors++;
      $display("FAIL scale_data: lat=%0d got %0d %0d %0d %0d want %0d %0d", lat,
               $signed(OUTsumr), $signed(OUTsumi), $signed(OUTsubr), $signed(OUTsubi), $signed(er), $signed(ei));
    end
  endtask

  task automatic test_back_to_back;
    int sent, got, dups;
    logic [16:0] esr, esi, edr, edi;
    sent = 0; got = 0; dups = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 6);
      scale = 1'b0;
      INwr = 16'h8000; INwi = 16'd0;
      if (sent < 8) begin
        INar = 16'(10*sent + 5); INai = 16'(-7*sent);
        INbr = 16'(3*sent - 4);  INbi = 16'(sent + 2);
        in_valid = 1'b1;
      end else
        in_valid = 1'b0;
      #1;
      if (cyc >= 4 && cyc <= 6) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_stall c%0d: got rdy=%b vld=%b want 0 1", cyc, in_ready, out_valid);
        end
      end
      if (out_valid) begin
        // With W = -1: sum = A - B, sub = A + B.
        esr = 17'(7*got + 9);  esi = 17'(-8*got - 2);
        edr = 17'(13*got + 1); edi = 17'(-6*got + 2);
        checks++;
        if (OUTsumr !== esr || OUTsumi !== esi || OUTsubr !== edr || OUTsubi !== edi) begin
          errors++;
          $display("FAIL b2b_data #%0d c%0d: got %0d %0d %0d %0d want %0d %0d %0d %0d", got, cyc,
                   $signed(OUTsumr), $signed(OUTsumi), $signed(OUTsubr), $signed(OUTsubi),
                   $signed(esr), $signed(esi), $signed(edr), $signed(edi));
        end
        if (out_ready) got++;
      end
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) dups++;
    end
    checks++;
    if (got !== 8 || sent !== 8 || dups !== 0) begin
      errors++;
      $display("FAIL b2b_count: got out=%0d in=%0d extra=%0d want 8 8 0", got, sent, dups);
    end
  endtask

  task automatic test_reset_flush;
    int seen;
    seen = 0;
    out_ready = 1'b1;
    @(negedge clk);
    INar = 16'd11; INai = 16'd0; INbr = 16'd1; INbi = 16'd0; INwr = 16'h8000; INwi = 16'd0;
    in_valid = 1'b1;
    @(negedge clk);
    INar = 16'd22;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_next: got vld=%b want 0", out_valid);
    end
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL flush_emit: got %0d outputs want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_scale();
    test_back_to_back();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
